// File: rtl/fu_wb_buffer.sv
// Writeback buffer between one execute unit and the CDB arbiter: a small FIFO
// whose head requests the CDB. Optional zero-latency bypass under WB_BYPASS_EN.
`timescale 1ns/1ps

module fu_wb_buffer #(
  parameter  int DEPTH = 2,
  parameter  int PKT_W = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_result,
  output logic             cdb_req,
  output logic [PKT_W-1:0] cdb_result,
  input  logic             cdb_gnt,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_fifo_req;
  logic             w_push;
  logic             w_pop;
  logic [PKT_W-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The counter alone decides full/empty, so pointers may wrap freely.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_fifo_req = ~w_empty & ~flush & ~rst;
  assign w_pop      = w_fifo_req & cdb_gnt;

  assign in_ready   = ~w_full & ~rst;
  assign occupancy  = r_count;

`ifdef WB_BYPASS_EN
  logic w_bypass;

  // An empty buffer offers the incoming packet directly; if granted it never lands.
  assign w_bypass   = w_empty & in_valid & ~flush & ~rst;
  assign cdb_req    = w_fifo_req | w_bypass;
  assign cdb_result = w_fifo_req ? w_head : (w_bypass ? in_result : '0);
  assign w_push     = in_valid & in_ready & ~flush & ~(w_bypass & cdb_gnt);
`else
  assign cdb_req    = w_fifo_req;
  assign cdb_result = w_fifo_req ? w_head : '0;
  assign w_push     = in_valid & in_ready & ~flush;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full));

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(DEPTH));

  // A flush on the following cycle legitimately drops the request.
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (cdb_req && !cdb_gnt && !flush) |=> (!cdb_req || $stable(cdb_result)));
`endif

endmodule
